// File: rtl/irq_onehot_arbiter.sv
// Rising-edge interrupt capture with round-robin arbitration among unmasked pending bits.
// One grant is presented at a time as a registered one-hot vector with a valid/ack handshake.
module irq_onehot_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             ack,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             grant_valid,
    output logic [N_REQ-1:0] pending,
    output logic             lost,
    output logic             fsm_state
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Handshake: a grant is live while grant_valid=1; it is consumed on the rising
    // clock edge where grant_valid=1 and ack=1. ack with grant_valid=0 is ignored.

    state_t             state_q;
    logic [N_REQ-1:0]   req_q;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   grant_q;
    logic               valid_q;
    logic               lost_q, lost_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [PTR_W-1:0]   next_ptr;

    logic [N_REQ-1:0]   rise;
    logic [N_REQ-1:0]   acked;
    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   win_oh;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   idx_p;
    logic               found;

    always_comb begin
        rise      = req & ~req_q;
        acked     = (state_q == HOLD && ack) ? grant_q : '0;
        // A new edge on the bit being acked wins over the clear and is not a loss.
        pending_d = (pending_q & ~acked) | rise;
        lost_d    = lost_q | (|(rise & pending_q & ~acked));
        elig      = pending_q & mask;
    end

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        idx_p   = '0;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_p = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && elig[idx_p]) begin
                found         = 1'b1;
                win_oh[idx_p] = 1'b1;
                win_idx       = idx_p;
            end
        end
    end

    assign next_ptr = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            rr_ptr_q  <= '0;
            gidx_q    <= '0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        grant_q <= win_oh;
                        valid_q <= 1'b1;
                        gidx_q  <= win_idx;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        grant_q  <= '0;
                        valid_q  <= 1'b0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_onehot = grant_q;
    assign grant_valid  = valid_q;
    assign pending      = pending_q;
    assign lost         = lost_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// Directed bench for irq_onehot_arbiter: reset, latency, round-robin order, fairness,
// masking, lost-edge flag and asynchronous reset during a held grant.
module tb_irq_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [3:0] grant_onehot;
  logic       grant_valid;
  logic [3:0] pending;
  logic       lost;
  logic       fsm_state;

  int checks = 0;
  int errors = 0;

  irq_onehot_arbiter #(.N_REQ(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mask         (mask),
    .ack          (ack),
    .grant_onehot (grant_onehot),
    .grant_valid  (grant_valid),
    .pending      (pending),
    .lost         (lost),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // downstream Encoder_4 model
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    mask  = 4'b1111;
    ack   = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", grant_valid); end
    checks++; if (grant_onehot !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant_onehot); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b exp 0000", pending); end
    checks++; if (lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b exp 0", lost); end
    checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", fsm_state); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL single_pending got %b exp 0001", pending); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", grant_valid); end
    tick();
    checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", grant_valid); end
    checks++; if (grant_onehot !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", grant_onehot); end
    checks++; if (enc4(grant_onehot) !== 2'b00) begin errors++; $display("FAIL single_enc got %b exp 00", enc4(grant_onehot)); end
    checks++; if (fsm_state !== 1'b1) begin errors++; $display("FAIL single_state got %b exp 1", fsm_state); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_ack_valid got %b exp 0", grant_valid); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_ack_pending got %b exp 0000", pending); end
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL single_no_regrant got %b exp 0", grant_valid); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1010;
    tick();
    req = 4'b0000;
    tick();
    checks++; if (grant_onehot !== 4'b0010) begin errors++; $display("FAIL rr_first got %b exp 0010", grant_onehot); end
    checks++; if (enc4(grant_onehot) !== 2'b01) begin errors++; $display("FAIL rr_first_enc got %b exp 01", enc4(grant_onehot)); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rr_gap got %b exp 0", grant_valid); end
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL rr_pending got %b exp 1000", pending); end
    tick();
    checks++; if (grant_onehot !== 4'b1000) begin errors++; $display("FAIL rr_second got %b exp 1000", grant_onehot); end
    checks++; if (enc4(grant_onehot) !== 2'b11) begin errors++; $display("FAIL rr_second_enc got %b exp 11", enc4(grant_onehot)); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rr_drained got %b exp 0000", pending); end
    // pointer should have wrapped to 0, so bit 0 beats bit 1
    req = 4'b0011;
    tick();
    req = 4'b0000;
    tick();
    checks++; if (grant_onehot !== 4'b0001) begin errors++; $display("FAIL rr_wrap got %b exp 0001", grant_onehot); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [3:0] prev_g;
    do_reset();
    prev_g = 4'b0000;
    req = 4'b0011;
    tick();
    req = 4'b0000;
    tick();
    for (int g = 0; g < 6; g++) begin
      exp_g = (g % 2 == 0) ? 4'b0001 : 4'b0010;
      checks++; if (grant_onehot !== exp_g || grant_valid !== 1'b1) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", g, grant_onehot, exp_g); end
      checks++; if (grant_onehot === prev_g) begin errors++; $display("FAIL fair_repeat%0d got %b exp not %b", g, grant_onehot, prev_g); end
      prev_g = grant_onehot;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      req = exp_g;
      tick();
      req = 4'b0000;
    end
  endtask

  task automatic test_mask();
    int bad;
    do_reset();
    mask = 4'b1011;
    req  = 4'b0100;
    tick();
    req = 4'b0000;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (grant_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mask_hold got %0d valid cycles exp 0", bad); end
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL mask_pending got %b exp 0100", pending); end
    mask = 4'b1111;
    tick();
    checks++; if (grant_onehot !== 4'b0100 || grant_valid !== 1'b1) begin errors++; $display("FAIL mask_unmask got %b/%b exp 0100/1", grant_onehot, grant_valid); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_lost();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    checks++; if (grant_onehot !== 4'b0100) begin errors++; $display("FAIL lost_grant got %b exp 0100", grant_onehot); end
    // edge coincident with ack: event kept, no loss
    req = 4'b0100;
    ack = 1'b1;
    tick();
    req = 4'b0000;
    ack = 1'b0;
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL lost_coinc_pending got %b exp 0100", pending); end
    checks++; if (lost !== 1'b0) begin errors++; $display("FAIL lost_coinc_flag got %b exp 0", lost); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL lost_coinc_valid got %b exp 0", grant_valid); end
    tick();
    checks++; if (grant_onehot !== 4'b0100) begin errors++; $display("FAIL lost_regrant got %b exp 0100", grant_onehot); end
    // second edge while pending and unacked
    req = 4'b0100;
    mask = 4'b0000;
    tick();
    req = 4'b0000;
    checks++; if (lost !== 1'b1) begin errors++; $display("FAIL lost_set got %b exp 1", lost); end
    checks++; if (grant_onehot !== 4'b0100 || grant_valid !== 1'b1) begin errors++; $display("FAIL lost_hold got %b/%b exp 0100/1", grant_onehot, grant_valid); end
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++; if (lost !== 1'b1) begin errors++; $display("FAIL lost_sticky got %b exp 1", lost); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL lost_pending got %b exp 0000", pending); end
    mask = 4'b1111;
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    checks++; if (grant_onehot !== 4'b0001) begin errors++; $display("FAIL arst_grant got %b exp 0001", grant_onehot); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b0 || grant_onehot !== 4'b0000) begin errors++; $display("FAIL arst_drop got %b/%b exp 0/0000", grant_valid, grant_onehot); end
    checks++; if (pending !== 4'b0000 || lost !== 1'b0) begin errors++; $display("FAIL arst_clear got %b/%b exp 0000/0", pending, lost); end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (grant_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL arst_no_grant got %0d valid cycles exp 0", bad); end
  endtask

  // report
  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    mask  = 4'b1111;
    ack   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_mask();
    test_lost();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
